// File: rtl/router_pkt_reader.sv
// router_pkt_reader: drains one packet at a time from a router FIFO with a
// 1-cycle registered read latency. Every byte is forwarded to a valid/ready
// sink through a 2-entry skid buffer, and the trailing parity byte is checked.
// A starvation watchdog aborts a stalled packet and requests a FIFO soft reset.
//
// Ports:
//   clock, resetn     clock and asynchronous active-low reset
//   fifo_empty        FIFO empty flag
//   fifo_data         FIFO read data, valid the cycle after a pop
//   fifo_read_enb     FIFO pop request (combinational, never while empty)
//   sink_ready        downstream accepts the current byte
//   out_valid         out_data holds a byte
//   out_data          packet byte, forwarded unmodified
//   out_sop, out_eop  header / parity byte qualifiers
//   parity_err        1-cycle pulse on parity mismatch
//   soft_reset_req    1-cycle pulse on watchdog abort
//   busy              packet in progress
//   pkt_count         completed packets, wrapping
module router_pkt_reader #(
    parameter int unsigned TIMEOUT = 30
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_read_enb,
    input  logic        sink_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic        parity_err,
    output logic        soft_reset_req,
    output logic        busy,
    output logic [15:0] pkt_count
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned POPS_W = 7;
    localparam int unsigned WD_W   = 8;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        BODY  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t              state;
    logic                inflight;
    logic [POPS_W-1:0]   pops_left;
    logic [DATA_W-1:0]   acc;
    logic                bad_parity;
    logic [WD_W-1:0]     wd_cnt;

    // Second skid-buffer entry; the first entry is the out_* register set.
    logic                tail_valid;
    logic [DATA_W-1:0]   tail_data;
    logic                tail_sop;
    logic                tail_eop;

    logic                transfer;
    logic [1:0]          level;
    logic                room;
    logic                want;
    logic                starve;
    logic                abort;
    logic                arrive;
    logic                last_byte;
    logic                push_sop;
    logic                eop_xfer;

    // Pop control, arrival decode and watchdog trigger.
    always_comb begin
        transfer  = out_valid & sink_ready;
        // Bytes that will sit in the buffer next cycle without a new pop.
        level     = 2'(out_valid) + 2'(tail_valid) + 2'(inflight) - 2'(transfer);
        room      = (level < 2'd2);
        want      = (state == IDLE) || ((state == BODY) && (pops_left != '0));
        fifo_read_enb = resetn & want & ~fifo_empty & room;
        // Only FIFO starvation counts; a full buffer (sink stall) never does.
        starve    = (state == BODY) && (pops_left != '0) && fifo_empty && room;
        abort     = starve && (wd_cnt == WD_W'(TIMEOUT - 1));
        arrive    = inflight && ((state == HDR) || (state == BODY));
        // pops_left already counts the previous pop, so zero means this is parity.
        last_byte = arrive && (state == BODY) && (pops_left == '0);
        push_sop  = (state == HDR);
        eop_xfer  = transfer & out_eop;
    end

    // State, skid buffer, watchdog and status registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            busy           <= 1'b0;
            inflight       <= 1'b0;
            pops_left      <= '0;
            acc            <= '0;
            bad_parity     <= 1'b0;
            wd_cnt         <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_sop        <= 1'b0;
            out_eop        <= 1'b0;
            tail_valid     <= 1'b0;
            tail_data      <= '0;
            tail_sop       <= 1'b0;
            tail_eop       <= 1'b0;
            parity_err     <= 1'b0;
            soft_reset_req <= 1'b0;
            pkt_count      <= '0;
        end else begin
            parity_err     <= 1'b0;
            soft_reset_req <= 1'b0;
            inflight       <= fifo_read_enb;

            // Skid buffer: head shifts on transfer, arrivals fill the first free slot.
            if (abort) begin
                out_valid  <= 1'b0;
                tail_valid <= 1'b0;
            end else if (transfer) begin
                if (tail_valid) begin
                    out_data   <= tail_data;
                    out_sop    <= tail_sop;
                    out_eop    <= tail_eop;
                    tail_valid <= arrive;
                    if (arrive) begin
                        tail_data <= fifo_data;
                        tail_sop  <= push_sop;
                        tail_eop  <= last_byte;
                    end
                end else if (arrive) begin
                    out_data <= fifo_data;
                    out_sop  <= push_sop;
                    out_eop  <= last_byte;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (arrive) begin
                if (out_valid) begin
                    tail_valid <= 1'b1;
                    tail_data  <= fifo_data;
                    tail_sop   <= push_sop;
                    tail_eop   <= last_byte;
                end else begin
                    out_valid <= 1'b1;
                    out_data  <= fifo_data;
                    out_sop   <= push_sop;
                    out_eop   <= last_byte;
                end
            end

            // Watchdog: consecutive starved cycles; holds while the sink stalls.
            if (abort || (state != BODY) || !fifo_empty) begin
                wd_cnt <= '0;
            end else if (starve) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end

            unique case (state)
                IDLE: begin
                    if (fifo_read_enb) begin
                        state <= HDR;
                        busy  <= 1'b1;
                    end
                end
                HDR: begin
                    if (inflight) begin
                        pops_left <= POPS_W'(fifo_data[7:2]) + POPS_W'(1);
                        acc       <= fifo_data;
                        state     <= BODY;
                    end
                end
                BODY: begin
                    if (abort) begin
                        state          <= IDLE;
                        busy           <= 1'b0;
                        soft_reset_req <= 1'b1;
                    end else begin
                        if (fifo_read_enb) begin
                            pops_left <= pops_left - POPS_W'(1);
                        end
                        if (last_byte) begin
                            bad_parity <= (fifo_data != acc);
                            state      <= DRAIN;
                        end else if (arrive) begin
                            acc <= acc ^ fifo_data;
                        end
                    end
                end
                DRAIN: begin
                    if (eop_xfer) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        pkt_count  <= pkt_count + CNT_W'(1);
                        parity_err <= bad_parity;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
